mux_rr_arbiter_8to1: RTL and testbench
======================================

# mux_rr_arbiter_8to1

Round-robin arbiter that shares one 8:1 WIDTH-bit multiplexer among eight requesters and registers the selected word toward a single consumer. Each requester uses a valid/ready pair (req/gnt), and the consumer uses o_valid/o_ready. The block sits between eight producer channels and one shared downstream sink. It issues the mux select, captures the muxed data, and guarantees fair, starvation-free access.

## Interface
- WIDTH, 4: data width of every input and of o_data
- SWIDTH, 3: select width; fixed at 3 (eight sources)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  8  req[k]=1: source k has a word on ik; held with ik stable until gnt[k]
- i0..i7  in  WIDTH each  source data words
- gnt  out  8  one-hot, combinational; gnt[k]=1: source k is captured on this rising edge
- sel  out  SWIDTH  index of the source currently held in o_data (registered)
- o_valid  out  1  o_data holds an unconsumed word
- o_data  out  WIDTH  captured word from source sel
- o_ready  in  1  consumer accepts o_data when o_valid & o_ready

## Operation
- load = (|req) & (~o_valid | o_ready). The output slot is free or is draining this cycle.
- Winner: the first k with req[k]=1, searched ptr, ptr+1, … mod 8 (wrap 7→0).
- gnt = load ? onehot(winner) : 8'h00. At most one bit is ever set.
- On a clock edge with load=1:
  - o_data <= i[winner]
  - sel <= winner
  - o_valid <= 1
  - ptr <= (winner+1) mod 8
- On a clock edge with o_valid & o_ready & ~load: o_valid <= 0. o_data and sel hold their last values.
- On a clock edge with o_valid & ~o_ready: o_data, sel and ptr are stable, and gnt=0.
- ptr is internal, 3 bits. It changes only on load.
- Fairness: a continuously requesting source is granted within 8 loads.
- A source dropping req before gnt is legal. It is simply not considered.

## Timing
- Reset values: o_valid=0, o_data=0, sel=0, ptr=0, gnt=0 (no req while in reset).
- Latency: 1 cycle from a req edge (slot free) to o_valid=1 with the data.
- Throughput: 1 word/cycle when o_ready is held high. Back-to-back grants need no bubble.
- Simultaneous consume and load: the new word replaces the old one in the same edge, and o_valid stays 1.
- rst_n falling mid-transfer immediately clears o_valid/o_data/sel/ptr. Any held word is dropped. Requesters keep req asserted and are re-arbitrated from ptr=0 after release.
- gnt is combinational from req/o_valid/o_ready/ptr. There is no combinational path from any i* to any output.

## Configuration
- MUX_ARB_FIXED_PRIO_EN defined: fixed priority. The winner is the lowest-index k with req[k]=1, ptr is removed, and starvation of high indices is permitted.
- MUX_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.

## Test plan
- Reset: assert rst_n=0 with req=8'hFF → o_valid=0, o_data=0, sel=0, gnt=0. Release → first gnt=8'h01.
- Single source: req=8'h08, i3=4'hA, o_ready=1 → gnt=8'h08 that cycle. Next cycle o_valid=1, o_data=4'hA, sel=3.
- Full rotation: req=8'hFF held, ik=k, o_ready=1 → gnt walks 01,02,04,…,80,01 on consecutive cycles. o_data walks 0..7,0 one cycle behind with no bubbles.
- Backpressure: o_valid=1, o_ready=0 for 5 cycles with req=8'h30 → gnt=0, o_data/sel stable. Raise o_ready → gnt=8'h10 the same cycle, o_data=i4 next cycle.
- Wrap-around: after a grant to source 6 (ptr=7), req=8'h41 → gnt=8'h01 (source 0 wins over 6).
- Async reset mid-transfer: o_valid=1, o_data=4'h5, drop rst_n between clock edges → outputs clear before the next edge. After release, req=8'h80 → sel=7.

Source files
------------

// File: rtl/mux_rr_arbiter_8to1_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter_8to1_if
// Description : Bundle of the eight-requester / single-consumer handshake
//               and data signals for mux_rr_arbiter_8to1.
//               master : producer + consumer side (drives req, i0..i7,
//                        o_ready; observes gnt, sel, o_valid, o_data)
//               slave  : arbiter side (the opposite directions)
// Parameters  : WIDTH  - data width of every source word and of o_data
//               SWIDTH - select width (3 for eight sources)
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_rr_arbiter_8to1_if #(
    parameter int WIDTH  = 4,
    parameter int SWIDTH = 3
);
    logic [7:0]        req;
    logic [WIDTH-1:0]  i0;
    logic [WIDTH-1:0]  i1;
    logic [WIDTH-1:0]  i2;
    logic [WIDTH-1:0]  i3;
    logic [WIDTH-1:0]  i4;
    logic [WIDTH-1:0]  i5;
    logic [WIDTH-1:0]  i6;
    logic [WIDTH-1:0]  i7;
    logic [7:0]        gnt;
    logic [SWIDTH-1:0] sel;
    logic              o_valid;
    logic [WIDTH-1:0]  o_data;
    logic              o_ready;

    modport master (
        output req, i0, i1, i2, i3, i4, i5, i6, i7, o_ready,
        input  gnt, sel, o_valid, o_data
    );

    modport slave (
        input  req, i0, i1, i2, i3, i4, i5, i6, i7, o_ready,
        output gnt, sel, o_valid, o_data
    );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter_8to1.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter_8to1
// Description : Round-robin arbiter sharing one 8:1 WIDTH-bit mux among eight
//               valid/ready requesters; the selected word is registered into
//               a single output slot toward one consumer.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - mux_rr_arbiter_8to1_if.slave
//                       req[7:0], i0..i7 in ; gnt[7:0] out (combinational)
//                       sel, o_valid, o_data out (registered) ; o_ready in
// Config      : MUX_ARB_FIXED_PRIO_EN defined -> fixed priority (lowest
//               index wins, no rotation pointer). Undefined -> round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter_8to1 #(
    parameter int WIDTH  = 4,
    parameter int SWIDTH = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mux_rr_arbiter_8to1_if.slave bus
);

    logic [WIDTH-1:0]  src [8];
    logic              load;
    logic [2:0]        winner;
    logic [7:0]        gnt_vec;
    logic              valid_q;
    logic [WIDTH-1:0]  data_q;
    logic [SWIDTH-1:0] sel_q;

    assign src[0] = bus.i0;
    assign src[1] = bus.i1;
    assign src[2] = bus.i2;
    assign src[3] = bus.i3;
    assign src[4] = bus.i4;
    assign src[5] = bus.i5;
    assign src[6] = bus.i6;
    assign src[7] = bus.i7;

    // The slot can take a word when it is empty or being drained this cycle.
    // rst_n is folded in so no grant is shown while the block is held in reset.
    assign load = rst_n & (|bus.req) & (~valid_q | bus.o_ready);

`ifdef MUX_ARB_FIXED_PRIO_EN
    // Lowest requesting index wins; scanning downward leaves the lowest.
    always_comb begin
        winner = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (bus.req[k]) begin
                winner = 3'(k);
            end
        end
    end
`else
    logic [2:0] ptr;
    logic [2:0] cand;
    logic       found;

    // First requester at or after ptr, wrapping naturally in 3-bit arithmetic.
    always_comb begin
        winner = ptr;
        cand   = ptr;
        found  = 1'b0;
        for (int d = 0; d < 8; d++) begin
            cand = ptr + 3'(d);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // The pointer moves only on a load, to one past the source just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 3'd0;
        end else if (load) begin
            ptr <= winner + 3'd1;
        end
    end
`endif

    always_comb begin
        gnt_vec = 8'h00;
        if (load) begin
            gnt_vec[winner] = 1'b1;
        end
    end

    // Output slot: a load overwrites (also when draining in the same edge),
    // a drain with nothing new just clears the valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= src[winner];
            sel_q   <= SWIDTH'(winner);
        end else if (valid_q && bus.o_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.gnt     = gnt_vec;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.sel     = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter_8to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter_8to1
// Description : Self-checking bench for mux_rr_arbiter_8to1. A behavioural
//               model (slot contents + rotation origin) predicts every output
//               on each falling edge; directed steps pin known literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter_8to1;

    localparam int WIDTH  = 4;
    localparam int SWIDTH = 3;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din [8];

    int total = 0;
    int bad   = 0;

    mux_rr_arbiter_8to1_if #(.WIDTH(WIDTH), .SWIDTH(SWIDTH)) bus_if ();

    assign bus_if.i0 = din[0];
    assign bus_if.i1 = din[1];
    assign bus_if.i2 = din[2];
    assign bus_if.i3 = din[3];
    assign bus_if.i4 = din[4];
    assign bus_if.i5 = din[5];
    assign bus_if.i6 = din[6];
    assign bus_if.i7 = din[7];

    mux_rr_arbiter_8to1 #(.WIDTH(WIDTH), .SWIDTH(SWIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    int               m_ptr;
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_sel;

    // Winner = requesting source with the smallest forward distance from ptr.
    function automatic int pick(input logic [7:0] r, input int p);
        int best;
        int bestd;
        best  = -1;
        bestd = 99;
        for (int k = 0; k < 8; k++) begin
            if (r[k]) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
                if (k < bestd) begin bestd = k; best = k; end
`else
                if (((k - p + 8) % 8) < bestd) begin bestd = (k - p + 8) % 8; best = k; end
`endif
            end
        end
        return best;
    endfunction

    always @(negedge clk) begin
        int  w;
        bit  ld;
        logic [7:0] eg;
        if (!rst_n) begin
            m_ptr = 0; m_valid = 0; m_data = '0; m_sel = 0;
            chk("m_rst_valid", 32'(bus_if.o_valid), 32'd0);
            chk("m_rst_data",  32'(bus_if.o_data),  32'd0);
            chk("m_rst_sel",   32'(bus_if.sel),     32'd0);
            chk("m_rst_gnt",   32'(bus_if.gnt),     32'd0);
        end else begin
            chk("m_valid", 32'(bus_if.o_valid), 32'(m_valid));
            chk("m_data",  32'(bus_if.o_data),  32'(m_data));
            chk("m_sel",   32'(bus_if.sel),     32'(m_sel));
            ld = (bus_if.req != 8'h00) && (!m_valid || bus_if.o_ready);
            w  = pick(bus_if.req, m_ptr);
            eg = ld ? (8'h01 << w) : 8'h00;
            chk("m_gnt", 32'(bus_if.gnt), 32'(eg));
            if (ld) begin
                m_data  = din[w];
                m_sel   = w;
                m_valid = 1;
                m_ptr   = (w + 1) % 8;
            end else if (m_valid && bus_if.o_ready) begin
                m_valid = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus + literal expectations ----------------
    initial begin
        rst_n = 1'b0;
        bus_if.req = 8'hFF;
        bus_if.o_ready = 1'b0;
        for (int k = 0; k < 8; k++) din[k] = '0;
        tick(); tick();
        chk("rst_valid", 32'(bus_if.o_valid), 32'd0);
        chk("rst_data",  32'(bus_if.o_data),  32'd0);
        chk("rst_sel",   32'(bus_if.sel),     32'd0);
        chk("rst_gnt",   32'(bus_if.gnt),     32'd0);
        rst_n = 1'b1;
        #3 chk("first_gnt", 32'(bus_if.gnt), 32'h01);
        tick();

        // single source
        bus_if.req = 8'h08; din[3] = 4'hA; bus_if.o_ready = 1'b1;
        #3 chk("single_gnt", 32'(bus_if.gnt), 32'h08);
        tick();
        chk("single_valid", 32'(bus_if.o_valid), 32'd1);
        chk("single_data",  32'(bus_if.o_data),  32'hA);
        chk("single_sel",   32'(bus_if.sel),     32'd3);

        // full rotation from a fresh pointer
        rst_n = 1'b0; bus_if.req = 8'h00;
        tick();
        rst_n = 1'b1; bus_if.req = 8'hFF;
        for (int k = 0; k < 8; k++) din[k] = 4'(k);
        for (int c = 0; c < 9; c++) begin
            #3 chk("rot_gnt", 32'(bus_if.gnt), 32'(8'h01 << (c % 8)));
            tick();
            chk("rot_data",  32'(bus_if.o_data),  32'(c % 8));
            chk("rot_valid", 32'(bus_if.o_valid), 32'd1);
        end

        // backpressure
        bus_if.o_ready = 1'b0; bus_if.req = 8'h30;
        for (int c = 0; c < 5; c++) begin
            #3 chk("bp_gnt", 32'(bus_if.gnt), 32'h00);
            chk("bp_data", 32'(bus_if.o_data), 32'd0);
            chk("bp_sel",  32'(bus_if.sel),    32'd0);
            tick();
        end
        bus_if.o_ready = 1'b1;
        #3 chk("bp_release_gnt", 32'(bus_if.gnt), 32'h10);
        tick();
        chk("bp_data4", 32'(bus_if.o_data), 32'd4);
        chk("bp_sel4",  32'(bus_if.sel),    32'd4);

        // wrap-around: serve 6, then 0 beats 6
        bus_if.req = 8'h40;
        #3 chk("wrap_gnt6", 32'(bus_if.gnt), 32'h40);
        tick();
        bus_if.req = 8'h41;
        #3 chk("wrap_gnt0", 32'(bus_if.gnt), 32'h01);
        tick();
        chk("wrap_sel0", 32'(bus_if.sel), 32'd0);

        // async reset while a word is held
        bus_if.req = 8'h20; din[5] = 4'h5;
        tick();
        bus_if.o_ready = 1'b0; bus_if.req = 8'h00;
        chk("ar_held_data",  32'(bus_if.o_data),  32'h5);
        chk("ar_held_valid", 32'(bus_if.o_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus_if.o_valid), 32'd0);
        chk("ar_data",  32'(bus_if.o_data),  32'd0);
        chk("ar_sel",   32'(bus_if.sel),     32'd0);
        tick();
        rst_n = 1'b1; bus_if.req = 8'h80; bus_if.o_ready = 1'b1;
        tick();
        chk("ar_sel7",  32'(bus_if.sel),    32'd7);
        chk("ar_data7", 32'(bus_if.o_data), 32'd7);

        // randomized traffic, checked by the model
        for (int c = 0; c < 600; c++) begin
            bus_if.req     = 8'($urandom);
            if ($urandom_range(0, 3) == 0) bus_if.req = 8'h00;
            bus_if.o_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 8; k++) din[k] = 4'($urandom);
            rst_n = ($urandom_range(0, 59) != 0);
            tick();
        end
        rst_n = 1'b1;
        bus_if.req = 8'h00;
        bus_if.o_ready = 1'b1;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
